game_referee: RTL and testbench

- Sits downstream of the board stage and consumes the board state bus and move-submit strobe.
- On every submitted move, scans the eight winning lines sequentially and counts occupied cells.
- Declares a win, a draw or an illegal board, holds the result for output/player/ai to sample, then pulses a game-reset request back to the board.

---
 rtl/game_referee_if.sv | 43 ++++
 rtl/game_referee.sv | 230 +++++++++++++++++++++++
 tb/tb_game_referee.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_referee_if.sv
// Board-stage <-> referee bus: board snapshot, move strobe and the
// referee's result/handshake outputs. Optional win/draw statistics
// appear when REFEREE_STATS_EN is defined.
interface game_referee_if;
  logic [17:0] board_state;
  logic        submit;
  logic        busy;
  logic        result_valid;
  logic [1:0]  winner;
  logic [3:0]  win_line;
  logic [3:0]  move_count;
  logic        illegal;
  logic        reset_req;
`ifdef REFEREE_STATS_EN
  logic [7:0]  x_wins;
  logic [7:0]  o_wins;
  logic [7:0]  draws;

  modport master (
    output board_state, submit,
    input  busy, result_valid, winner, win_line, move_count, illegal,
           reset_req, x_wins, o_wins, draws
  );

  modport slave (
    input  board_state, submit,
    output busy, result_valid, winner, win_line, move_count, illegal,
           reset_req, x_wins, o_wins, draws
  );
`else
  modport master (
    output board_state, submit,
    input  busy, result_valid, winner, win_line, move_count, illegal,
           reset_req
  );

  modport slave (
    input  board_state, submit,
    output busy, result_valid, winner, win_line, move_count, illegal,
           reset_req
  );
`endif
endinterface

// File: rtl/game_referee.sv
// Tic-tac-toe referee. On each submitted move it snapshots the board,
// walks the nine cells / eight lines one per cycle, then declares a
// win, draw or illegal board, holds the result for HOLD_CYCLES cycles
// and pulses reset_req back to the board stage.
// Optional feature macro: REFEREE_STATS_EN adds saturating x_wins,
// o_wins and draws counters (cleared only by rst_n).
module game_referee #(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned DRAW_EN_MOVES = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  game_referee_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DECIDE,
    HOLD,
    RST_PULSE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] DRAW_N    = 4'(DRAW_EN_MOVES);
  localparam logic [3:0] NO_LINE   = 4'd15;

  state_t      state, state_nx;

  logic [17:0] snap;
  logic [3:0]  idx;
  logic [3:0]  occ;
  logic        inv_flag;
  logic        win_found;
  logic [2:0]  win_idx;
  logic [1:0]  win_val;
  logic [7:0]  hold_cnt;

  logic [1:0]  winner_q;
  logic [3:0]  win_line_q;
  logic [3:0]  move_count_q;
  logic        illegal_q;

  logic        busy_c;
  logic        result_valid_c;
  logic        reset_req_c;

  logic [1:0]  cur_code;
  logic [1:0]  la, lb, lc;
  logic        line_win;
  logic        bad_board;
  logic        is_draw;
  logic        hold_done;

`ifdef REFEREE_STATS_EN
  logic [7:0]  x_wins_q;
  logic [7:0]  o_wins_q;
  logic [7:0]  draws_q;
`endif

  // Cell indices {a,b,c} of winning line l.
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    logic [11:0] r;
    unique case (l)
      3'd0: r = {4'd0, 4'd1, 4'd2};
      3'd1: r = {4'd3, 4'd4, 4'd5};
      3'd2: r = {4'd6, 4'd7, 4'd8};
      3'd3: r = {4'd0, 4'd3, 4'd6};
      3'd4: r = {4'd1, 4'd4, 4'd7};
      3'd5: r = {4'd2, 4'd5, 4'd8};
      3'd6: r = {4'd0, 4'd4, 4'd8};
      3'd7: r = {4'd2, 4'd4, 4'd6};
    endcase
    return r;
  endfunction

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] c);
    logic [4:0] base;
    base = {c, 1'b0};
    return b[base +: 2];
  endfunction

  // Per-cycle scan evaluation of the current cell and line, plus decide terms.
  always_comb begin
    logic [11:0] cells;
    cells     = line_cells(idx[2:0]);
    cur_code  = cell_of(snap, idx);
    la        = cell_of(snap, cells[11:8]);
    lb        = cell_of(snap, cells[7:4]);
    lc        = cell_of(snap, cells[3:0]);
    line_win  = !idx[3] && (la != 2'b00) && (la == lb) && (la == lc);
    bad_board = inv_flag || ({1'b0, occ} != ({1'b0, move_count_q} + 5'd1));
    is_draw   = (occ == DRAW_N);
    hold_done = (hold_cnt == HOLD_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (bus.submit) state_nx = SCAN;
      SCAN:      if (idx == 4'd8) state_nx = DECIDE;
      DECIDE:    state_nx = (bad_board || win_found || is_draw) ? HOLD : IDLE;
      HOLD:      if (hold_done) state_nx = RST_PULSE;
      RST_PULSE: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_c         = 1'b0;
    result_valid_c = 1'b0;
    reset_req_c    = 1'b0;
    unique case (state)
      SCAN, DECIDE: busy_c         = 1'b1;
      HOLD:         result_valid_c = 1'b1;
      RST_PULSE:    reset_req_c    = 1'b1;
      default:      ;
    endcase
  end

  // Snapshot, scan accumulators, hold counter and held results.
  // Results are cleared on the HOLD exit edge so the RST_PULSE cycle
  // already shows reset values alongside reset_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap         <= '0;
      idx          <= '0;
      occ          <= '0;
      inv_flag     <= 1'b0;
      win_found    <= 1'b0;
      win_idx      <= '0;
      win_val      <= '0;
      hold_cnt     <= '0;
      winner_q     <= '0;
      win_line_q   <= NO_LINE;
      move_count_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.submit) begin
            snap      <= bus.board_state;
            idx       <= '0;
            occ       <= '0;
            inv_flag  <= 1'b0;
            win_found <= 1'b0;
            win_idx   <= '0;
            win_val   <= '0;
          end
        end
        SCAN: begin
          if (idx != 4'd8) idx <= idx + 4'd1;
          if (cur_code != 2'b00) occ <= occ + 4'd1;
          if (cur_code == 2'b11) inv_flag <= 1'b1;
          if (line_win && !win_found) begin
            win_found <= 1'b1;
            win_idx   <= idx[2:0];
            win_val   <= la;
          end
        end
        DECIDE: begin
          move_count_q <= occ;
          hold_cnt     <= '0;
          if (bad_board) begin
            illegal_q  <= 1'b1;
            winner_q   <= 2'b00;
            win_line_q <= NO_LINE;
          end else if (win_found) begin
            winner_q   <= win_val;
            win_line_q <= {1'b0, win_idx};
          end else if (is_draw) begin
            winner_q   <= 2'b11;
            win_line_q <= NO_LINE;
          end
        end
        HOLD: begin
          if (hold_done) begin
            winner_q     <= '0;
            win_line_q   <= NO_LINE;
            move_count_q <= '0;
            illegal_q    <= 1'b0;
            hold_cnt     <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REFEREE_STATS_EN
  // Game statistics, bumped from the held winner as the game is closed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_wins_q <= '0;
      o_wins_q <= '0;
      draws_q  <= '0;
    end else if (state == HOLD && hold_done) begin
      unique case (winner_q)
        2'b01:   if (x_wins_q != 8'hFF) x_wins_q <= x_wins_q + 8'd1;
        2'b10:   if (o_wins_q != 8'hFF) o_wins_q <= o_wins_q + 8'd1;
        2'b11:   if (draws_q  != 8'hFF) draws_q  <= draws_q  + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.x_wins = x_wins_q;
  assign bus.o_wins = o_wins_q;
  assign bus.draws  = draws_q;
`endif

  assign bus.busy         = busy_c;
  assign bus.result_valid = result_valid_c;
  assign bus.reset_req    = reset_req_c;
  assign bus.winner       = winner_q;
  assign bus.win_line     = win_line_q;
  assign bus.move_count   = move_count_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_game_referee.sv
// Bench for game_referee: table of submitted boards with expected
// results, checked through a scoreboard queue, plus hand-written
// sequences for reset-during-scan and submit-while-busy.
module tb_game_referee;

  localparam int unsigned HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  game_referee_if bus ();

  game_referee #(.HOLD_CYCLES(HOLD), .DRAW_EN_MOVES(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] brd;
    logic        rv;
    logic [1:0]  w;
    logic [3:0]  wl;
    logic [3:0]  mc;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
  endtask

  // Board string: 'X', 'O', '#' (invalid code), anything else empty.
  function automatic logic [17:0] mk(input string s);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      case (s[i])
        "X":     b[2*i +: 2] = 2'b01;
        "O":     b[2*i +: 2] = 2'b10;
        "#":     b[2*i +: 2] = 2'b11;
        default: b[2*i +: 2] = 2'b00;
      endcase
    end
    return b;
  endfunction

  function automatic vec_t mv(input string s, input logic rv, input logic [1:0] w,
                              input logic [3:0] wl, input logic [3:0] mc, input logic ill);
    vec_t v;
    v.brd = mk(s); v.rv = rv; v.w = w; v.wl = wl; v.mc = mc; v.ill = ill;
    return v;
  endfunction

  // Non-terminal legal move: only move_count changes.
  function automatic vec_t nt(input string s, input logic [3:0] mc);
    return mv(s, 1'b0, 2'b00, 4'd15, mc, 1'b0);
  endfunction

  function automatic logic [11:0] obs();
    return {bus.result_valid, bus.winner, bus.win_line, bus.move_count, bus.illegal};
  endfunction

  // Wait out the hold window, check its length, the cleared outputs and a single pulse.
  task automatic hold_and_pulse(input string tag);
    int n;
    n = 0;
    while (!bus.reset_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " hold_len"}, n, HOLD);
    check({tag, " pulse_clear"}, {obs(), bus.busy}, {1'b0, 2'b00, 4'd15, 4'd0, 1'b0, 1'b0});
    @(negedge clk);
    check({tag, " pulse_once"}, bus.reset_req, 1'b0);
  endtask

  // Submit one board, wait for the scan to complete, score against the queue.
  task automatic do_move(input vec_t e, input string tag);
    int   n;
    vec_t got;
    exp_q.push_back(e);
    @(negedge clk);
    bus.board_state = e.brd;
    bus.submit      = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    n = 1;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 11);
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
    end else begin
      got = exp_q.pop_front();
      check({tag, " result"}, obs(), {got.rv, got.w, got.wl, got.mc, got.ill});
      if (got.rv) hold_and_pulse(tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rr;

    // Game 1: X wins row 0 on the fifth move.
    vecs.push_back(nt("X........", 1));
    vecs.push_back(nt("X..O.....", 2));
    vecs.push_back(nt("XX.O.....", 3));
    vecs.push_back(nt("XX.OO....", 4));
    vecs.push_back(mv("XXXOO....", 1, 2'b01, 4'd0, 5, 0));
    // Game 2: full board draw X O X / X O O / O X X.
    vecs.push_back(nt("X........", 1));
    vecs.push_back(nt("XO.......", 2));
    vecs.push_back(nt("XOX......", 3));
    vecs.push_back(nt("XOX.O....", 4));
    vecs.push_back(nt("XOXXO....", 5));
    vecs.push_back(nt("XOXXO.O..", 6));
    vecs.push_back(nt("XOXXO.OX.", 7));
    vecs.push_back(nt("XOXXOOOX.", 8));
    vecs.push_back(mv("XOXXOOOXX", 1, 2'b11, 4'd15, 9, 0));
    // Game 3: O wins the anti-diagonal (line 7).
    vecs.push_back(nt("X........", 1));
    vecs.push_back(nt("X.O......", 2));
    vecs.push_back(nt("XXO......", 3));
    vecs.push_back(nt("XXO.O....", 4));
    vecs.push_back(nt("XXO.O...X", 5));
    vecs.push_back(mv("XXO.O.O.X", 1, 2'b10, 4'd7, 6, 0));
    // Game 4: last move completes row 0 and column 0 on a full board.
    vecs.push_back(nt(".X.......", 1));
    vecs.push_back(nt(".X..O....", 2));
    vecs.push_back(nt(".XX.O....", 3));
    vecs.push_back(nt(".XX.OO...", 4));
    vecs.push_back(nt(".XXXOO...", 5));
    vecs.push_back(nt(".XXXOO.O.", 6));
    vecs.push_back(nt(".XXXOOXO.", 7));
    vecs.push_back(nt(".XXXOOXOO", 8));
    vecs.push_back(mv("XXXXOOXOO", 1, 2'b01, 4'd0, 9, 0));
    // Game 5: count jumps from 2 to 4.
    vecs.push_back(nt("X........", 1));
    vecs.push_back(nt("XO.......", 2));
    vecs.push_back(mv("XOXO.....", 1, 2'b00, 4'd15, 4, 1));
    // Game 6: invalid cell code with otherwise correct count.
    vecs.push_back(mv("#........", 1, 2'b00, 4'd15, 1, 1));

    bus.board_state = '0;
    bus.submit      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {obs(), bus.busy, bus.reset_req},
          {1'b0, 2'b00, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < vecs.size(); i++)
      do_move(vecs[i], $sformatf("vec%0d", i));

`ifdef REFEREE_STATS_EN
    check("stats", {bus.x_wins, bus.o_wins, bus.draws}, {8'd2, 8'd1, 8'd1});
`endif

    // Submit while busy is ignored; board changes during scan do not matter.
    @(negedge clk);
    bus.board_state = mk("X........");
    bus.submit      = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    n = 1;
    repeat (3) begin
      @(negedge clk);
      n++;
    end
    bus.board_state = mk("XO.......");
    bus.submit      = 1'b1;
    @(negedge clk);
    n++;
    bus.submit = 1'b0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("busy_submit latency", n, 11);
    check("busy_submit result", obs(), {1'b0, 2'b00, 4'd15, 4'd1, 1'b0});
    repeat (5) @(negedge clk);
    check("busy_submit no_requeue", bus.busy, 1'b0);

    // Reset asserted in scan cycle 4 (move_count is 1 beforehand).
    @(negedge clk);
    bus.board_state = mk("XO.......");
    bus.submit      = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_scan busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_scan reset_clear", {obs(), bus.busy, bus.reset_req},
          {1'b0, 2'b00, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0});
`ifdef REFEREE_STATS_EN
    check("stats_cleared", {bus.x_wins, bus.o_wins, bus.draws}, 24'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rr = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.reset_req) rr++;
    end
    check("mid_scan no_reset_req", rr, 0);
    do_move(nt("X........", 1), "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
